xmemrd_stream: RTL and testbench

Read-data stage directly downstream of the two-level address generator in a Versat memory unit. It forwards generated addresses and enables to the memory read port and tracks read latency. It captures returned words into a small register FIFO and presents them as a valid/ready stream to the datapath. Completion and overflow status are reported back to the unit controller.

---
 rtl/xversat_pkg.sv | 19 +
 rtl/xfifo_ff.sv | 63 ++++++
 rtl/xmemrd_stream.sv | 93 +++++++++
 tb/tb_xmemrd_stream.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xversat_pkg.sv
// Shared definitions for the Versat memory unit blocks.
package xversat_pkg;

  localparam int RD_LAT_MAX = 4;
  localparam int FIFO_DEPTH_W_DFLT = 2;

  typedef logic [FIFO_DEPTH_W_DFLT:0] fifo_level_t;

  // Keeps the tracking register width legal even for out-of-range latencies.
  function automatic int clamp_lat(input int lat);
    if (lat < 1)
      return 1;
    else if (lat > RD_LAT_MAX)
      return RD_LAT_MAX;
    else
      return lat;
  endfunction

endpackage

// File: rtl/xfifo_ff.sv
// Register-based first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module xfifo_ff
  import xversat_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [DATA_W-1:0]  data_o,
  output logic [DEPTH_W:0]   level_o,
  output logic [DEPTH_W:0]   level_next_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q;
  logic [DEPTH_W-1:0] rd_ptr_q;
  logic [DEPTH_W:0]   level_q;
  logic               push_ok;
  logic               pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (DEPTH_W + 1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign level_next_o = clear_i ? '0
                      : level_q + (DEPTH_W + 1)'(push_ok) - (DEPTH_W + 1)'(pop_ok);

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_next_o;
      if (clear_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) begin
          mem_q[wr_ptr_q] <= data_i;
          wr_ptr_q        <= wr_ptr_q + DEPTH_W'(1);
        end
        if (pop_ok) rd_ptr_q <= rd_ptr_q + DEPTH_W'(1);
      end
    end
  end

endmodule

// File: rtl/xmemrd_stream.sv
// Read-data stage: forwards generator reads to memory, tracks read latency
// and streams returned words out of a small FIFO with done/overflow status.
module xmemrd_stream
  import xversat_pkg::*;
#(
  parameter int MEM_ADDR_W   = 10,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int FIFO_DEPTH_W = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    run_i,
  input  logic [MEM_ADDR_W-1:0]   addr_i,
  input  logic                    mem_en_i,
  input  logic                    done_i,
  output logic [MEM_ADDR_W-1:0]   mem_addr_o,
  output logic                    mem_en_o,
  input  logic [DATA_W-1:0]       mem_data_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [FIFO_DEPTH_W:0]   level_o,
  output logic                    done_o,
  output logic                    overflow_o
);

  localparam int LAT = clamp_lat(RD_LAT);

  logic [LAT-1:0]        track_q;
  logic [LAT-1:0]        track_next;
  logic [LAT:0]          track_shift;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [FIFO_DEPTH_W:0] level_next;
  logic                  done_seen_q;
  logic                  done_seen_next;
  logic                  done_q;
  logic                  overflow_q;

  assign mem_addr_o = addr_i;
  assign mem_en_o   = mem_en_i;

  // run_i wipes in-flight reads but the read issued in the run cycle still enters.
  assign track_shift = {(run_i ? {LAT{1'b0}} : track_q), mem_en_i};
  assign track_next  = track_shift[LAT-1:0];
  assign push        = track_q[LAT-1] & ~run_i;

  assign valid_o = ~empty;
  assign pop     = valid_o & ready_i;

  assign done_seen_next = run_i ? 1'b0 : (done_seen_q | done_i);

  xfifo_ff #(
    .DATA_W  (DATA_W),
    .DEPTH_W (FIFO_DEPTH_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clear_i      (run_i),
    .push_i       (push),
    .pop_i        (pop),
    .data_i       (mem_data_i),
    .data_o       (data_o),
    .level_o      (level_o),
    .level_next_o (level_next),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      track_q     <= '0;
      done_seen_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      track_q     <= track_next;
      done_seen_q <= done_seen_next;
      done_q      <= done_seen_next & (track_next == '0) & (level_next == '0);
      if (run_i)
        overflow_q <= 1'b0;
      else if (push & full & ~pop)
        overflow_q <= 1'b1;
    end
  end

  assign done_o     = done_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_xmemrd_stream.sv
// Scoreboard bench for xmemrd_stream with RD_LAT=2 and a depth-4 FIFO.
module tb_xmemrd_stream;

  localparam int AW      = 10;
  localparam int DW      = 32;
  localparam int LAT     = 2;
  localparam int DEPTH_W = 2;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b0;
  logic            run_i = 1'b0;
  logic [AW-1:0]   addr_i = '0;
  logic            mem_en_i = 1'b0;
  logic            done_i = 1'b0;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_en_o;
  logic [DW-1:0]   mem_data_i;
  logic [DW-1:0]   data_o;
  logic            valid_o;
  logic            ready_i = 1'b0;
  logic [DEPTH_W:0] level_o;
  logic            done_o;
  logic            overflow_o;

  logic [DW-1:0]   exp_q[$];
  int              total = 0;
  int              bad = 0;
  logic [AW-1:0]   addr_pipe [LAT];

  xmemrd_stream #(
    .MEM_ADDR_W   (AW),
    .DATA_W       (DW),
    .RD_LAT       (LAT),
    .FIFO_DEPTH_W (DEPTH_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .run_i      (run_i),
    .addr_i     (addr_i),
    .mem_en_i   (mem_en_i),
    .done_i     (done_i),
    .mem_addr_o (mem_addr_o),
    .mem_en_o   (mem_en_o),
    .mem_data_i (mem_data_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .done_o     (done_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == 10'h03A) ? 32'hDEADBEEF : {{(DW-AW){1'b0}}, a};
  endfunction

  // Memory returns the word for an address LAT cycles after it was presented.
  always @(posedge clk_i) begin
    addr_pipe[0] <= mem_addr_o;
    for (int k = 1; k < LAT; k++) addr_pipe[k] <= addr_pipe[k-1];
  end
  assign mem_data_i = mem_word(addr_pipe[LAT-1]);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [AW-1:0] a, input logic run, input logic rdy);
    @(posedge clk_i);
    #1;
    mem_en_i = en;
    addr_i   = a;
    run_i    = run;
    ready_i  = rdy;
  endtask

  // Every accepted word is compared against the scoreboard head.
  always @(negedge clk_i) begin
    if (rst_n_i && valid_o && ready_i) begin
      checkOutput("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) checkOutput("stream_data", data_o, exp_q.pop_front());
    end
  end

  initial begin
    $display("[TB] reset and passthrough");
    mem_en_i = 1'b1;
    addr_i   = 10'h155;
    #3;
    checkOutput("rst_passthru_en", 32'(mem_en_o), 32'd1);
    checkOutput("rst_passthru_addr", 32'(mem_addr_o), 32'h155);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_level", 32'(level_o), 32'd0);
    checkOutput("rst_data", data_o, 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_ovf", 32'(overflow_o), 32'd0);
    #4;
    mem_en_i = 1'b0;
    addr_i   = '0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, AW'(i), 1'b0, 1'b0);
      @(negedge clk_i);
      checkOutput("idle_valid", 32'(valid_o), 32'd0);
      checkOutput("idle_level", 32'(level_o), 32'd0);
      checkOutput("idle_done", 32'(done_o), 32'd0);
      checkOutput("idle_ovf", 32'(overflow_o), 32'd0);
      checkOutput("idle_en", 32'(mem_en_o), 32'(mem_en_i));
    end

    $display("[TB] single read latency");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 0, 10'h03A, 1'b0, 1'b0);
      if (i == 0) exp_q.push_back(32'hDEADBEEF);
      @(negedge clk_i);
      checkOutput("lat_valid", 32'(valid_o), 32'(i == 3));
    end
    checkOutput("lat_data", data_o, 32'hDEADBEEF);
    checkOutput("lat_level", 32'(level_o), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("lat_level_after_pop", 32'(level_o), 32'd0);

    $display("[TB] streaming");
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i < 8, AW'(i), 1'b0, 1'b1);
      if (i < 8) exp_q.push_back(32'(i));
      if (i == 8) done_i = 1'b1;
      @(negedge clk_i);
      if (i >= 3) checkOutput("stream_valid", 32'(valid_o), 32'd1);
      if (i == 10) checkOutput("stream_done_early", 32'(done_o), 32'd0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk_i);
    checkOutput("stream_done", 32'(done_o), 32'd1);
    checkOutput("stream_ovf", 32'(overflow_o), 32'd0);
    checkOutput("stream_level", 32'(level_o), 32'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    done_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(i < 6, 10'h010 + AW'(i), 1'b0, 1'b0);
      if (i < 4) exp_q.push_back(32'h10 + 32'(i));
      @(negedge clk_i);
      if (i == 0) checkOutput("bp_done_cleared", 32'(done_o), 32'd0);
      if (i == 6) begin
        checkOutput("bp_level_full", 32'(level_o), 32'd4);
        checkOutput("bp_ovf_before", 32'(overflow_o), 32'd0);
      end
      if (i >= 7) begin
        checkOutput("bp_level_sat", 32'(level_o), 32'd4);
        checkOutput("bp_ovf_set", 32'(overflow_o), 32'd1);
      end
    end
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("bp_level_drained", 32'(level_o), 32'd0);
    checkOutput("bp_ovf_sticky", 32'(overflow_o), 32'd1);

    $display("[TB] run mid-stream");
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i < 3) || (i >= 4), 10'h030 + AW'(i), i == 5, 1'b0);
      if (i < 3) exp_q.push_back(32'h30 + 32'(i));
      if (i == 5) begin
        exp_q.delete();
        exp_q.push_back(32'h35);
      end
      @(negedge clk_i);
      if (i == 5) begin
        checkOutput("run_level_before", 32'(level_o), 32'd3);
        checkOutput("run_ovf_before", 32'(overflow_o), 32'd1);
      end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("run_level_cleared", 32'(level_o), 32'd0);
    checkOutput("run_ovf_cleared", 32'(overflow_o), 32'd0);
    checkOutput("run_done", 32'(done_o), 32'd0);
    checkOutput("run_valid", 32'(valid_o), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("run_stale_dropped", 32'(level_o), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("run_new_level", 32'(level_o), 32'd1);
    checkOutput("run_new_data", data_o, 32'h35);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("run_level_end", 32'(level_o), 32'd0);

    $display("[TB] full with simultaneous pop");
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i < 5, 10'h020 + AW'(i), 1'b0, i == 6);
      if (i < 5) exp_q.push_back(32'h20 + 32'(i));
      @(negedge clk_i);
      if (i == 6) checkOutput("fp_level_full", 32'(level_o), 32'd4);
      if (i == 7) begin
        checkOutput("fp_level_held", 32'(level_o), 32'd4);
        checkOutput("fp_no_ovf", 32'(overflow_o), 32'd0);
      end
    end
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("fp_level_drained", 32'(level_o), 32'd0);
    checkOutput("fp_ovf_end", 32'(overflow_o), 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] asynchronous reset mid-run");
    for (int i = 0; i < 4; i++) applyStimulus(i < 3, 10'h040 + AW'(i), 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("ar_level_before", 32'(level_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("ar_level_async", 32'(level_o), 32'd0);
    checkOutput("ar_valid_async", 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("ar_late_data_ignored", 32'(level_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
